mux_rr_scheduler: RTL and testbench
===================================

# mux_rr_scheduler

Round-robin scheduler that shares the 16:1 bit-select datapath (`mux_16x1`) among 16 requesters. Each requester raises a request, the block grants exactly one at a time, drives the mux select to that requester's index, captures the selected data bit, and presents it with its index on a valid/ready output stream. It sits between the requester bank and the downstream serial consumer.

## Interface
- `NUM_REQ`, 16: number of requesters and data lines. Fixed at 16 for this revision.
- `SEL_WIDTH`, 4: select width, log2(`NUM_REQ`).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req`  in  16  per-requester request, level-sensitive.
- `a_in`  in  16  data lines into the mux; bit i belongs to requester i.
- `out_ready`  in  1  downstream accepts the output when high.
- `grant`  out  16  one-hot grant, registered.
- `sel`  out  4  registered mux select, equal to the granted index.
- `out_valid`  out  1  output bit and index are valid.
- `out_bit`  out  1  captured `a_in[sel]`.
- `out_idx`  out  4  index that produced `out_bit`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Reset values:
  - `grant`=0, `sel`=0, `out_valid`=0, `out_bit`=0, `out_idx`=0, `busy`=0.
  - Round-robin pointer `ptr`=0; state IDLE.
- Arbitration: winner is the first set bit of `req` scanning `ptr`, `ptr`+1, … 15, 0, … `ptr`-1.
  - All index arithmetic is modulo 16 and 4 bits wide; the 4-bit add wraps naturally.
- States:
  - IDLE:
    - If `req`≠0: `sel`←winner, `grant`←onehot(winner); go to SEL.
    - Otherwise stay in IDLE.
  - SEL:
    - `out_bit`←`a_in[sel]`, `out_idx`←`sel`, `out_valid`←1; go to OUT.
    - `a_in` is sampled only in this state.
  - OUT:
    - `out_valid`, `out_bit`, `out_idx`, `sel` and `grant` stay stable while `out_ready`=0.
    - On `out_valid`&&`out_ready`: `ptr`←`sel`+1 and `out_valid`←0.
      - If `req`≠0 at that edge: arbitrate immediately, scanning from `sel`+1 (the updated pointer, not the old one). Load the new `sel`/`grant` and go to SEL.
      - Else: `grant`←0 and go to IDLE.
- Requests:
  - Deasserting `req[i]` after grant does not abort; the transfer completes.
  - Asserting `req` during SEL or OUT is only seen at the next arbitration point.
- The granted requester's `req` bit is still eligible at the next arbitration, but it has lowest priority.
- Reset mid-operation: all registers return to reset values immediately (asynchronous). An in-flight transfer is dropped with no `out_valid`, and `ptr` returns to 0.

## Timing
- `req` seen high at edge N in IDLE:
  - `grant`/`sel` valid after edge N.
  - `out_valid` high after edge N+1.
- Minimum latency is 2 cycles from the request edge to `out_valid`.
- Back-to-back throughput is one transfer per 2 cycles when `out_ready` is held high (the OUT→SEL path).
- `out_bit` reflects `a_in` at the SEL edge only; later changes on `a_in` do not affect the held output.
- `grant` is never multi-hot. `grant`≠0 exactly when the state is SEL or OUT.
- `busy` is a registered decode of the state.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package `mux_sched_pkg`:
  - `NUM_REQ`, `SEL_WIDTH` constants.
  - State enum {IDLE, SEL, OUT}.
  - Function `rr_pick(req, ptr)` that returns the winner index.
- One sub-module: an instance of the existing `mux_16x1` (`DATA_WIDTH`=`NUM_REQ`, `SEL_WIDTH`=`SEL_WIDTH`), fed by `a_in` and the registered `sel`. Its output is captured in SEL.
- Arbitration logic, pointer and FSM live in a single top module.

## Test plan
- Reset then single request:
  - `req`=16'h0020, `a_in`=16'hB0F3, `out_ready`=1.
  - Expect `grant`=16'h0020 and `sel`=5 one edge later, then `out_valid`=1, `out_bit`=1, `out_idx`=5 the next edge.
  - Then `ptr`=6 and the block returns to IDLE.
- Round-robin fairness:
  - `req`=16'hFFFF held, `out_ready`=1, starting from reset.
  - Expect `out_idx` sequence 0,1,2,…,15,0 with `out_valid` every 2nd cycle.
- Wrap-around:
  - Force `ptr`=15 via a prior grant of 14.
  - `req`=16'h8001: expect 15 first, then 0.
  - With `req`=16'h0001 only after granting 0: expect 0 again.
- Backpressure:
  - `out_ready`=0 for 5 cycles in OUT while `a_in` toggles.
  - Expect `out_valid`, `out_bit`, `out_idx` and `grant` constant.
  - Completion occurs on the cycle `out_ready` rises.
- Request drop and late arrival:
  - Deassert the granted `req` bit in SEL: the transfer still completes.
  - A new `req` bit arriving in OUT is granted at the handshake edge, with no IDLE cycle.
- Reset mid-transfer:
  - Assert `rst_n`=0 asynchronously during OUT.
  - Expect `out_valid`, `grant` and `busy` low before the next clock edge.
  - After release with `req`=16'h0004: expect `out_idx`=2.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// Shared constants, FSM states and round-robin pick helper
// for the 16-requester bit-select scheduler.
package mux_sched_pkg;

  localparam int NUM_REQ   = 16;
  localparam int SEL_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // First set request scanning ptr, ptr+1, ... with natural 4-bit wrap.
  function automatic logic [SEL_WIDTH-1:0] rr_pick(
    input logic [NUM_REQ-1:0]   req,
    input logic [SEL_WIDTH-1:0] ptr
  );
    logic [SEL_WIDTH-1:0] idx;
    logic                 found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + SEL_WIDTH'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mux_16x1.sv
// Shared bit-select datapath: y = a_in[sel].
// Purely combinational; the scheduler registers its output.
module mux_16x1 #(
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = 4
) (
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [SEL_WIDTH-1:0]  sel,
  output logic                  y
);

  assign y = a_in[sel];

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler sharing one 16:1 bit mux among 16
// requesters; result leaves on a valid/ready stream.
module mux_rr_scheduler
  import mux_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   a_in,
  input  logic                 out_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 out_valid,
  output logic                 out_bit,
  output logic [SEL_WIDTH-1:0] out_idx,
  output logic                 busy
);

  state_e               state_q, state_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 valid_q, valid_d;
  logic                 bit_q, bit_d;
  logic [SEL_WIDTH-1:0] idx_q, idx_d;
  logic                 busy_q;
  logic [SEL_WIDTH-1:0] nxt_ptr;
  logic [SEL_WIDTH-1:0] win;
  logic                 mux_y;

  mux_16x1 #(
    .DATA_WIDTH (NUM_REQ),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_mux (
    .a_in (a_in),
    .sel  (sel_q),
    .y    (mux_y)
  );

  // After a handshake the scan restarts just past the served index.
  assign nxt_ptr = sel_q + 4'd1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    valid_d = valid_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    win     = '0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (|req) begin
          win          = rr_pick(req, ptr_q);
          sel_d        = win;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          state_d      = SEL;
        end
      end
      (state_q == SEL): begin
        bit_d   = mux_y;
        idx_d   = sel_q;
        valid_d = 1'b1;
        state_d = OUT;
      end
      (state_q == OUT): begin
        if (valid_q && out_ready) begin
          ptr_d   = nxt_ptr;
          valid_d = 1'b0;
          grant_d = '0;
          if (|req) begin
            win          = rr_pick(req, nxt_ptr);
            sel_d        = win;
            grant_d[win] = 1'b1;
            state_d      = SEL;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      bit_q   <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign out_valid = valid_q;
  assign out_bit   = bit_q;
  assign out_idx   = idx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Self-checking bench for mux_rr_scheduler: vector table,
// directed corner sequences and a random run against a model.
module tb_mux_rr_scheduler;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic [15:0] a_in;
  logic        out_ready;
  logic [15:0] grant;
  logic [3:0]  sel;
  logic        out_valid;
  logic        out_bit;
  logic [3:0]  out_idx;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mux_rr_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .out_ready (out_ready),
    .grant     (grant),
    .sel       (sel),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .out_idx   (out_idx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0 = idle, 1 = select, 2 = output.
  int          m_phase, m_ptr, m_sel;
  logic [15:0] m_grant;
  logic        m_ov, m_ob;
  int          m_oi;

  function automatic int pick(logic [15:0] r, int p);
    for (int k = 0; k < 16; k++)
      if (r[(p + k) % 16]) return (p + k) % 16;
    return -1;
  endfunction

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_sel = 0;
    m_grant = '0; m_ov = 0; m_ob = 0; m_oi = 0;
  endtask

  task automatic model_edge();
    int w;
    case (m_phase)
      0: if (req != 0) begin
        w = pick(req, m_ptr);
        m_sel = w; m_grant = 16'(1) << w; m_phase = 1;
      end
      1: begin
        m_ob = a_in[m_sel]; m_oi = m_sel; m_ov = 1; m_phase = 2;
      end
      default: if (out_ready) begin
        m_ptr = (m_sel + 1) % 16;
        m_ov  = 0;
        if (req != 0) begin
          w = pick(req, m_ptr);
          m_sel = w; m_grant = 16'(1) << w; m_phase = 1;
        end else begin
          m_grant = '0; m_phase = 0;
        end
      end
    endcase
  endtask

  task automatic compare_model();
    check("grant", 32'(grant), 32'(m_grant));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("busy", 32'(busy), 32'(m_phase != 0));
    if (m_phase != 0) check("sel", 32'(sel), 32'(m_sel));
    if (m_ov) begin
      check("out_bit", 32'(out_bit), 32'(m_ob));
      check("out_idx", 32'(out_idx), 32'(m_oi));
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req = '0; a_in = '0; out_ready = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Step until out_valid; a missing transfer counts as a failure.
  task automatic wait_valid(string name, output int idx);
    idx = -1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (out_valid) begin
        idx = int'(out_idx);
        return;
      end
    end
    check({name, "_timeout"}, 32'(out_valid), 32'd1);
  endtask

  typedef struct {
    logic [15:0] req;
    logic [15:0] a_in;
    logic        rdy;
    logic        exp_valid;
    int          exp_idx;
    logic        exp_bit;
    logic [15:0] exp_grant;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int idx;
    int exp_i;
    logic [15:0] g0;
    logic        b0;
    logic [3:0]  i0;

    rst_n = 1'b0; req = '0; a_in = '0; out_ready = 1'b1;
    model_reset();
    #12;
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_sel", 32'(sel), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_bit", 32'(out_bit), 32'd0);
    check("reset_idx", 32'(out_idx), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single request, then a second request proving ptr moved to 6.
    vecs[0] = '{16'h0020, 16'hB0F3, 1, 0, 0, 0, 16'h0020};
    vecs[1] = '{16'h0000, 16'hB0F3, 1, 1, 5, 1, 16'h0020};
    vecs[2] = '{16'h0000, 16'hB0F3, 1, 0, 0, 0, 16'h0000};
    vecs[3] = '{16'h0060, 16'hB0F3, 1, 0, 0, 0, 16'h0040};
    vecs[4] = '{16'h0000, 16'hB0F3, 1, 1, 6, 1, 16'h0040};
    vecs[5] = '{16'h0000, 16'h0000, 1, 0, 0, 0, 16'h0000};
    for (int v = 0; v < 6; v++) begin
      req = vecs[v].req; a_in = vecs[v].a_in;
      out_ready = vecs[v].rdy;
      step();
      check("vec_valid", 32'(out_valid), 32'(vecs[v].exp_valid));
      check("vec_grant", 32'(grant), 32'(vecs[v].exp_grant));
      if (vecs[v].exp_valid) begin
        check("vec_idx", 32'(out_idx), 32'(vecs[v].exp_idx));
        check("vec_bit", 32'(out_bit), 32'(vecs[v].exp_bit));
      end
    end

    // Fairness: all requesting, valid every second cycle.
    do_reset();
    req = 16'hFFFF; a_in = 16'h5A3C; out_ready = 1'b1;
    step();
    exp_i = 0;
    for (int c = 0; c < 34; c++) begin
      step();
      check("rr_valid_cadence", 32'(out_valid), 32'(c % 2 == 0));
      if (out_valid) begin
        check("rr_idx", 32'(out_idx), 32'(exp_i % 16));
        exp_i++;
      end
    end
    check("rr_count", 32'(exp_i), 32'd17);

    // Wrap-around: serve 14, then 15, 0, and 0 again alone.
    do_reset();
    req = 16'h4000;
    wait_valid("wrap14", idx);
    check("wrap_first", 32'(idx), 32'd14);
    req = 16'h8001;
    wait_valid("wrap15", idx);
    check("wrap_15", 32'(idx), 32'd15);
    wait_valid("wrap0", idx);
    check("wrap_0", 32'(idx), 32'd0);
    req = 16'h0001;
    wait_valid("wrap0b", idx);
    check("wrap_0_again", 32'(idx), 32'd0);
    req = '0;
    step();

    // Backpressure: outputs hold while a_in toggles.
    do_reset();
    req = 16'h0100; a_in = 16'h0100; out_ready = 1'b0;
    wait_valid("bp", idx);
    req = '0;
    g0 = grant; b0 = out_bit; i0 = out_idx;
    check("bp_bit", 32'(b0), 32'd1);
    for (int c = 0; c < 5; c++) begin
      a_in = ~a_in;
      step();
      check("bp_valid_hold", 32'(out_valid), 32'd1);
      check("bp_bit_hold", 32'(out_bit), 32'(b0));
      check("bp_idx_hold", 32'(out_idx), 32'(i0));
      check("bp_grant_hold", 32'(grant), 32'(g0));
    end
    out_ready = 1'b1;
    step();
    check("bp_complete", 32'(out_valid), 32'd0);

    // Request drop in SEL, late arrival in OUT.
    do_reset();
    req = 16'h0008; a_in = 16'h0008;
    step();
    req = '0;
    step();
    check("drop_valid", 32'(out_valid), 32'd1);
    check("drop_idx", 32'(out_idx), 32'd3);
    req = 16'h0400;
    step();
    check("late_grant", 32'(grant), 32'h0400);
    check("late_busy", 32'(busy), 32'd1);
    req = '0;
    step();
    check("late_idx", 32'(out_idx), 32'd10);
    step();

    // Asynchronous reset during OUT.
    do_reset();
    req = 16'h0200; out_ready = 1'b0;
    wait_valid("rst", idx);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_grant", 32'(grant), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    model_reset();
    req = 16'h0004; out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_valid("post_rst", idx);
    check("post_rst_idx", 32'(idx), 32'd2);
    req = '0;
    step();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      req = ($urandom_range(0, 3) == 0) ? 16'h0000
            : 16'($urandom) & 16'($urandom);
      a_in = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      check("onehot", 32'($countones(grant) <= 1), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
